// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One radix-2 step per clock (shift-add multiply, restoring divide) on operand
// magnitudes. A final FIX cycle applies the sign correction and writes HI/LO,
// so every operation completes exactly WIDTH+1 edges after it is accepted.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  // acc: product upper half / partial remainder
  // qr:  multiplier being consumed (mul) / dividend shifting out, quotient shifting in (div)
  logic [WIDTH-1:0] acc, qr, m;
  logic             is_div, neg_q, neg_r, div0;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, mul_pick, div_rs, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] acc_n, qr_n, fix_hi, fix_lo;

  assign busy = (state != S_IDLE);

  // Operand magnitudes and signs at capture; op[0]=0 selects the signed forms.
  always_comb begin
    a_neg = ~op[0] & A[WIDTH-1];
    b_neg = ~op[0] & B[WIDTH-1];
    a_mag = a_neg ? -A : A;
    b_mag = b_neg ? -B : B;
  end

  // One radix-2 iteration: a single WIDTH+1-bit add or subtract plus shifts.
  always_comb begin
    mul_sum  = {1'b0, acc} + {1'b0, m};
    mul_pick = qr[0] ? mul_sum : {1'b0, acc};
    div_rs   = {acc, qr[WIDTH-1]};
    div_diff = div_rs - {1'b0, m};
    div_ge   = ~div_diff[WIDTH];
    if (is_div) begin
      // remainder stays below the divisor, so it always fits in WIDTH bits
      acc_n = div_ge ? div_diff[WIDTH-1:0] : div_rs[WIDTH-1:0];
      qr_n  = {qr[WIDTH-2:0], div_ge};
    end else begin
      acc_n = mul_pick[WIDTH:1];
      qr_n  = {mul_pick[0], qr[WIDTH-1:1]};
    end
  end

  // Sign correction. Divide by zero leaves |A| in the remainder and the
  // remainder takes the dividend's sign, so HI comes out equal to A without
  // special handling; only the quotient is forced to all ones.
  always_comb begin
    if (is_div) begin
      fix_lo = div0 ? '1 : (neg_q ? -qr : qr);
      fix_hi = neg_r ? -acc : acc;
    end else if (neg_q) begin
      // 2*WIDTH negate split into halves: carry into HI only when LO is zero
      fix_lo = -qr;
      fix_hi = ~acc + {{(WIDTH-1){1'b0}}, (qr == '0)};
    end else begin
      fix_lo = qr;
      fix_hi = acc;
    end
  end

  // Control FSM, datapath registers and HI/LO update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      acc    <= '0;
      qr     <= '0;
      m      <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt    <= '0;
            acc    <= '0;
            is_div <= op[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            div0   <= (B == '0);
            qr     <= op[1] ? a_mag : b_mag;
            m      <= op[1] ? b_mag : a_mag;
            state  <= S_RUN;
          end else begin
            if (mthi) hi <= A;
            if (mtlo) lo <= A;
          end
        end
        S_RUN: begin
          acc <= acc_n;
          qr  <= qr_n;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) state <= S_FIX;
        end
        S_FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
